// File: rtl/load_store_ctrl.sv
// load_store_ctrl: one-at-a-time load/store sequencer in front of the
// memory address resolver, with a timeout on every access.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req_*               request from execute (valid/ready handshake)
//   resp_*              response to consumer (rdata + err, valid/ready)
//   mem_read*           resolver read port one
//   mem_wren, mem_write* resolver write port
//
// Optional feature: define LSU_MISALIGN_CHECK_EN to reject misaligned
// half/word accesses and reserved size 11 with err 10 and no strobe.

module load_store_ctrl #(
    parameter int WORD_SIZE = 32,
    parameter int TIMEOUT   = 16,
    parameter int CNT_W     = $clog2(TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_store,
    input  logic                 req_sign,
    input  logic [1:0]           req_size,
    input  logic [WORD_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,

    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [WORD_SIZE-1:0] resp_rdata,
    output logic [1:0]           resp_err,

    output logic                 mem_read,
    output logic                 mem_read_sign,
    output logic [1:0]           mem_read_size,
    output logic [WORD_SIZE-1:0] mem_read_addr,
    input  logic [WORD_SIZE-1:0] mem_read_data,
    input  logic                 mem_read_valid,

    output logic                 mem_wren,
    output logic [1:0]           mem_write_size,
    output logic [WORD_SIZE-1:0] mem_write_addr,
    output logic [WORD_SIZE-1:0] mem_write_data,
    input  logic                 mem_write_valid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_TMO = 2'b01;
    localparam logic [1:0] ERR_MIS = 2'b10;

    state_t               state;
    state_t               state_nx;

    logic                 h_sign;
    logic [1:0]           h_size;
    logic [WORD_SIZE-1:0] h_addr;
    logic [WORD_SIZE-1:0] h_wdata;

    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nx;
    logic [WORD_SIZE-1:0] rdata_q;
    logic [WORD_SIZE-1:0] rdata_nx;
    logic [1:0]           err_q;
    logic [1:0]           err_nx;

    logic                 accept;
    logic                 misalign;
    logic                 timed_out;

`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        unique case (req_size)
            2'b01:   misalign = req_addr[0];
            2'b10:   misalign = |req_addr[1:0];
            2'b11:   misalign = 1'b1;
            default: misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    // Held low during reset so nothing is accepted while state is forced.
    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rdata_nx = rdata_q;
        err_nx   = err_q;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    cnt_nx   = '0;
                    rdata_nx = '0;
                    err_nx   = ERR_OK;
                    if (misalign) begin
                        err_nx   = ERR_MIS;
                        state_nx = RESP;
                    end else if (req_store) begin
                        state_nx = WR_WAIT;
                    end else begin
                        state_nx = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                // valid has priority over the final timeout cycle
                if (mem_read_valid) begin
                    rdata_nx = mem_read_data;
                    err_nx   = ERR_OK;
                    state_nx = RESP;
                end else if (timed_out) begin
                    rdata_nx = '0;
                    err_nx   = ERR_TMO;
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            WR_WAIT: begin
                if (mem_write_valid) begin
                    rdata_nx = '0;
                    err_nx   = ERR_OK;
                    state_nx = RESP;
                end else if (timed_out) begin
                    rdata_nx = '0;
                    err_nx   = ERR_TMO;
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= ERR_OK;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            rdata_q <= rdata_nx;
            err_q   <= err_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_sign  <= 1'b0;
            h_size  <= 2'b00;
            h_addr  <= '0;
            h_wdata <= '0;
        end else if (accept) begin
            h_sign  <= req_sign;
            h_size  <= req_size;
            h_addr  <= req_addr;
            h_wdata <= req_wdata;
        end
    end

    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Buses are zeroed whenever their strobe is low.
    assign mem_read      = (state == RD_WAIT);
    assign mem_read_sign = mem_read & h_sign;
    assign mem_read_size = mem_read ? h_size : 2'b00;
    assign mem_read_addr = mem_read ? h_addr : '0;

    assign mem_wren       = (state == WR_WAIT);
    assign mem_write_size = mem_wren ? h_size : 2'b00;
    assign mem_write_addr = mem_wren ? h_addr : '0;
    assign mem_write_data = mem_wren ? h_wdata : '0;

endmodule

// File: tb/tb_load_store_ctrl.sv
// tb_load_store_ctrl: directed bench for load_store_ctrl.
// Linear stimulus; expected values are hand-computed constants.

module tb_load_store_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic        req_sign = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        mem_read;
    logic        mem_read_sign;
    logic [1:0]  mem_read_size;
    logic [31:0] mem_read_addr;
    logic [31:0] mem_read_data = '0;
    logic        mem_read_valid = 1'b0;
    logic        mem_wren;
    logic [1:0]  mem_write_size;
    logic [31:0] mem_write_addr;
    logic [31:0] mem_write_data;
    logic        mem_write_valid = 1'b0;

    int checks = 0;
    int errors = 0;

    load_store_ctrl #(
        .WORD_SIZE(32),
        .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_store(req_store),
        .req_sign(req_sign),
        .req_size(req_size),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .mem_read(mem_read),
        .mem_read_sign(mem_read_sign),
        .mem_read_size(mem_read_size),
        .mem_read_addr(mem_read_addr),
        .mem_read_data(mem_read_data),
        .mem_read_valid(mem_read_valid),
        .mem_wren(mem_wren),
        .mem_write_size(mem_write_size),
        .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data),
        .mem_write_valid(mem_write_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic store, input logic sign,
                           input logic [1:0] size,
                           input logic [31:0] addr,
                           input logic [31:0] wdata);
        req_valid = 1'b1;
        req_store = store;
        req_sign  = sign;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    task automatic drop_req();
        req_valid = 1'b0;
        req_store = 1'b0;
        req_sign  = 1'b0;
        req_size  = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("back_idle", {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        // reset state
        #2 reset = 1'b1;
        #2;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", {30'd0, resp_err}, 32'd0);
        check("rst_mem_read", {31'd0, mem_read}, 32'd0);
        check("rst_mem_wren", {31'd0, mem_wren}, 32'd0);
        check("rst_raddr", mem_read_addr, 32'd0);
        check("rst_waddr", mem_write_addr, 32'd0);
        check("rst_wdata", mem_write_data, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rel_req_ready", {31'd0, req_ready}, 32'd1);

        // load word, valid in first wait cycle
        present(1'b0, 1'b0, 2'b10, 32'h0000_0010, 32'd0);
        check("ld_ready", {31'd0, req_ready}, 32'd1);
        tick();
        drop_req();
        check("ld_mem_read", {31'd0, mem_read}, 32'd1);
        check("ld_raddr", mem_read_addr, 32'h0000_0010);
        check("ld_rsize", {30'd0, mem_read_size}, 32'd2);
        check("ld_no_wren", {31'd0, mem_wren}, 32'd0);
        check("ld_nresp", {31'd0, resp_valid}, 32'd0);
        check("ld_busy", {31'd0, req_ready}, 32'd0);
        mem_read_valid = 1'b1;
        mem_read_data  = 32'hDEAD_BEEF;
        tick();
        mem_read_valid = 1'b0;
        mem_read_data  = '0;
        check("ld_resp", {31'd0, resp_valid}, 32'd1);
        check("ld_rdata", resp_rdata, 32'hDEAD_BEEF);
        check("ld_err", {30'd0, resp_err}, 32'd0);
        check("ld_rd_off", {31'd0, mem_read}, 32'd0);
        check("ld_raddr0", mem_read_addr, 32'd0);
        finish_resp();
        check("ld_ready2", {31'd0, req_ready}, 32'd1);

        // store byte, write_valid after 3 extra cycles
        present(1'b1, 1'b0, 2'b00, 32'h0000_1003, 32'h0000_00A5);
        tick();
        drop_req();
        for (int i = 1; i <= 4; i++) begin
            check("st_wren", {31'd0, mem_wren}, 32'd1);
            check("st_waddr", mem_write_addr, 32'h0000_1003);
            check("st_wdata", mem_write_data, 32'h0000_00A5);
            check("st_wsize", {30'd0, mem_write_size}, 32'd0);
            check("st_no_rd", {31'd0, mem_read}, 32'd0);
            check("st_nresp", {31'd0, resp_valid}, 32'd0);
            if (i == 4) mem_write_valid = 1'b1;
            tick();
        end
        mem_write_valid = 1'b0;
        check("st_resp", {31'd0, resp_valid}, 32'd1);
        check("st_err", {30'd0, resp_err}, 32'd0);
        check("st_rdata", resp_rdata, 32'd0);
        check("st_wren_off", {31'd0, mem_wren}, 32'd0);
        check("st_wdata0", mem_write_data, 32'd0);
        finish_resp();

        // unmapped load times out after TIMEOUT wait cycles
        present(1'b0, 1'b1, 2'b10, 32'h0000_5000, 32'd0);
        tick();
        drop_req();
        for (int i = 1; i <= 16; i++) begin
            check("to_mem_read", {31'd0, mem_read}, 32'd1);
            check("to_nresp", {31'd0, resp_valid}, 32'd0);
            tick();
        end
        check("to_resp", {31'd0, resp_valid}, 32'd1);
        check("to_err", {30'd0, resp_err}, 32'd1);
        check("to_rdata", resp_rdata, 32'd0);
        check("to_rd_off", {31'd0, mem_read}, 32'd0);

        // response held with resp_ready low; new request waits
        present(1'b1, 1'b0, 2'b10, 32'h0000_0020, 32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            check("hold_ready", {31'd0, req_ready}, 32'd0);
            check("hold_valid", {31'd0, resp_valid}, 32'd1);
            check("hold_err", {30'd0, resp_err}, 32'd1);
            check("hold_rdata", resp_rdata, 32'd0);
            check("hold_no_wren", {31'd0, mem_wren}, 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("hold_idle", {31'd0, req_ready}, 32'd1);
        check("hold_nresp", {31'd0, resp_valid}, 32'd0);
        tick();
        drop_req();
        check("nx_wren", {31'd0, mem_wren}, 32'd1);
        check("nx_waddr", mem_write_addr, 32'h0000_0020);
        check("nx_wdata", mem_write_data, 32'h1234_5678);
        mem_write_valid = 1'b1;
        tick();
        mem_write_valid = 1'b0;
        check("nx_resp", {31'd0, resp_valid}, 32'd1);
        check("nx_err", {30'd0, resp_err}, 32'd0);
        finish_resp();

        // valid on the last timeout cycle wins; late valid ignored
        present(1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'd0);
        tick();
        drop_req();
        for (int i = 1; i <= 16; i++) begin
            if (i == 16) begin
                mem_read_valid = 1'b1;
                mem_read_data  = 32'hCAFE_0001;
            end
            tick();
        end
        mem_read_data = 32'h5555_AAAA;
        check("edge_resp", {31'd0, resp_valid}, 32'd1);
        check("edge_err", {30'd0, resp_err}, 32'd0);
        check("edge_rdata", resp_rdata, 32'hCAFE_0001);
        tick();
        mem_read_valid = 1'b0;
        check("late_rdata", resp_rdata, 32'hCAFE_0001);
        check("late_err", {30'd0, resp_err}, 32'd0);
        finish_resp();

        // half load at an odd address
        present(1'b0, 1'b1, 2'b01, 32'h0000_0011, 32'd0);
        tick();
        drop_req();
`ifdef LSU_MISALIGN_CHECK_EN
        check("mis_no_rd", {31'd0, mem_read}, 32'd0);
        check("mis_no_wr", {31'd0, mem_wren}, 32'd0);
        check("mis_resp", {31'd0, resp_valid}, 32'd1);
        check("mis_err", {30'd0, resp_err}, 32'd2);
        check("mis_rdata", resp_rdata, 32'd0);
`else
        check("mis_rd", {31'd0, mem_read}, 32'd1);
        check("mis_raddr", mem_read_addr, 32'h0000_0011);
        check("mis_rsize", {30'd0, mem_read_size}, 32'd1);
        check("mis_rsign", {31'd0, mem_read_sign}, 32'd1);
        mem_read_valid = 1'b1;
        mem_read_data  = 32'hFFFF_8001;
        tick();
        mem_read_valid = 1'b0;
        mem_read_data  = '0;
        check("mis_resp", {31'd0, resp_valid}, 32'd1);
        check("mis_err", {30'd0, resp_err}, 32'd0);
        check("mis_rdata", resp_rdata, 32'hFFFF_8001);
`endif
        finish_resp();

        // reset in the middle of RD_WAIT
        present(1'b0, 1'b0, 2'b10, 32'h0000_0040, 32'd0);
        tick();
        drop_req();
        check("mr_rd", {31'd0, mem_read}, 32'd1);
        tick();
        #2 reset = 1'b1;
        #1;
        check("mr_rd_drop", {31'd0, mem_read}, 32'd0);
        check("mr_raddr0", mem_read_addr, 32'd0);
        check("mr_nresp", {31'd0, resp_valid}, 32'd0);
        check("mr_nready", {31'd0, req_ready}, 32'd0);
        tick();
        reset = 1'b0;
        mem_read_valid = 1'b1;
        mem_read_data  = 32'h0BAD_0BAD;
        tick();
        mem_read_valid = 1'b0;
        check("mr_idle", {31'd0, req_ready}, 32'd1);
        check("mr_nresp2", {31'd0, resp_valid}, 32'd0);
        present(1'b0, 1'b0, 2'b10, 32'h0000_0044, 32'd0);
        tick();
        drop_req();
        check("mr2_rd", {31'd0, mem_read}, 32'd1);
        check("mr2_raddr", mem_read_addr, 32'h0000_0044);
        tick();
        mem_read_valid = 1'b1;
        mem_read_data  = 32'h0102_0304;
        tick();
        mem_read_valid = 1'b0;
        check("mr2_resp", {31'd0, resp_valid}, 32'd1);
        check("mr2_rdata", resp_rdata, 32'h0102_0304);
        check("mr2_err", {30'd0, resp_err}, 32'd0);
        finish_resp();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
